prime_check: RTL and testbench

Iterative trial-division primality tester that sits directly upstream of the shared `divmod` divider and drives it through a go/ready port pair. It accepts one candidate `n` per request and issues one division per trial divisor `d` = 2, 3 (or 5, 7, …). It stops on the first zero remainder (composite) or once quotient < divisor (prime). The result goes to the prime-sequencing logic above it.

---
 rtl/prime_check.sv | 200 ++++++++++++++++++++
 tb/tb_prime_check.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prime_check.sv
// prime_check
// Iterative trial-division primality tester.
// It drives the shared divmod divider through a go/ready handshake.
// It accepts one candidate n per request.
// It divides n by d = 2, 3, ... until one of these happens:
//   - the remainder is zero (composite);
//   - the quotient drops below the divisor (prime);
//   - the divider reports an error.
//
// Optional feature: define PRIME_CHECK_ODD_STEP_EN to step the divisor
// 2, 3, 5, 7, ... instead of 2, 3, 4, 5, ...
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   go, n        start request (sampled while ready) and candidate
//   ready        idle / result valid
//   is_prime     result, valid when ready and not error
//   error        divider flagged an error during the last test
//   trials       divisions issued for the last/current test, saturating
//   div_go       one-cycle start pulse to the divider
//   div_a/div_b  dividend (captured n) / divisor d
//   div_ready    divider idle / result valid
//   div_error    divider error flag
//   div_q/div_r  divider quotient / remainder
module prime_check #(
    parameter int WIDTH_LOG = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       go,
    input  logic [(1<<WIDTH_LOG)-1:0]  n,
    output logic                       ready,
    output logic                       is_prime,
    output logic                       error,
    output logic [7:0]                 trials,
    output logic                       div_go,
    output logic [(1<<WIDTH_LOG)-1:0]  div_a,
    output logic [(1<<WIDTH_LOG)-1:0]  div_b,
    input  logic                       div_ready,
    input  logic                       div_error,
    input  logic [(1<<WIDTH_LOG)-1:0]  div_q,
    input  logic [(1<<WIDTH_LOG)-1:0]  div_r
);

    localparam int WIDTH = 1 << WIDTH_LOG;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ERROR
    } state_t;

    state_t             r_state, w_state;
    logic [WIDTH-1:0]   r_n, w_n;
    logic [WIDTH-1:0]   r_d, w_d;
    logic               r_ready, w_ready;
    logic               r_is_prime, w_is_prime;
    logic               r_error, w_error;
    logic [7:0]         r_trials, w_trials;
    logic               r_div_go, w_div_go;
    logic [WIDTH-1:0]   r_div_a, w_div_a;
    logic [WIDTH-1:0]   r_div_b, w_div_b;

    logic [WIDTH-1:0]   w_d_step;
    logic [7:0]         w_trials_inc;

    // Next trial divisor.
    // The odd-step build skips even divisors after 2.
    // Every composite has a smallest factor that is 2 or odd, so the
    // result is the same; only the number of trials differs.
`ifdef PRIME_CHECK_ODD_STEP_EN
    assign w_d_step = (r_d == WIDTH'(2)) ? WIDTH'(3) : r_d + WIDTH'(2);
`else
    assign w_d_step = r_d + WIDTH'(1);
`endif

    // The trial counter saturates instead of wrapping.
    assign w_trials_inc = (r_trials == 8'hFF) ? r_trials : r_trials + 8'd1;

    // State and registered outputs.
    // The reset is synchronous and returns everything to idle.
    // This clears div_go, so no pulse is left outstanding.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_n        <= '0;
            r_d        <= '0;
            r_ready    <= 1'b1;
            r_is_prime <= 1'b0;
            r_error    <= 1'b0;
            r_trials   <= 8'd0;
            r_div_go   <= 1'b0;
            r_div_a    <= '0;
            r_div_b    <= '0;
        end else begin
            r_state    <= w_state;
            r_n        <= w_n;
            r_d        <= w_d;
            r_ready    <= w_ready;
            r_is_prime <= w_is_prime;
            r_error    <= w_error;
            r_trials   <= w_trials;
            r_div_go   <= w_div_go;
            r_div_a    <= w_div_a;
            r_div_b    <= w_div_b;
        end
    end

    // Next-state and next-output logic.
    // The divider request (div_go, operands, trial count) is loaded on
    // every transition into ISSUE. As a result, div_go is high exactly
    // while the FSM sits in ISSUE.
    // This also puts the first pulse in the cycle right after the
    // accepted go.
    always_comb begin
        w_state    = r_state;
        w_n        = r_n;
        w_d        = r_d;
        w_ready    = r_ready;
        w_is_prime = r_is_prime;
        w_error    = r_error;
        w_trials   = r_trials;
        w_div_go   = 1'b0;
        w_div_a    = r_div_a;
        w_div_b    = r_div_b;

        case (r_state)
            S_IDLE, S_ERROR: begin
                if (go) begin
                    w_n      = n;
                    w_error  = 1'b0;
                    w_trials = 8'd0;
                    if (n < WIDTH'(2)) begin
                        w_is_prime = 1'b0;
                        w_state    = S_IDLE;
                    end else if (n < WIDTH'(4)) begin
                        w_is_prime = 1'b1;
                        w_state    = S_IDLE;
                    end else begin
                        w_d        = WIDTH'(2);
                        w_is_prime = 1'b0;
                        w_ready    = 1'b0;
                        w_state    = S_ISSUE;
                        w_div_go   = 1'b1;
                        w_div_a    = n;
                        w_div_b    = WIDTH'(2);
                        w_trials   = 8'd1;
                    end
                end
            end

            S_ISSUE: begin
                w_state = S_WAIT;
            end

            // The divider drops its ready on the edge that takes div_go.
            // Therefore the first WAIT cycle never sees a stale result.
            S_WAIT: begin
                if (div_ready) begin
                    if (div_error) begin
                        w_state    = S_ERROR;
                        w_ready    = 1'b1;
                        w_error    = 1'b1;
                        w_is_prime = 1'b0;
                    end else if (div_r == '0) begin
                        w_state    = S_IDLE;
                        w_ready    = 1'b1;
                        w_is_prime = 1'b0;
                    end else if (div_q < r_d) begin
                        // q < d means d*d > n, so no smaller factor exists.
                        w_state    = S_IDLE;
                        w_ready    = 1'b1;
                        w_is_prime = 1'b1;
                    end else begin
                        w_d      = w_d_step;
                        w_state  = S_ISSUE;
                        w_div_go = 1'b1;
                        w_div_a  = r_n;
                        w_div_b  = w_d_step;
                        w_trials = w_trials_inc;
                    end
                end
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign ready    = r_ready;
    assign is_prime = r_is_prime;
    assign error    = r_error;
    assign trials   = r_trials;
    assign div_go   = r_div_go;
    assign div_a    = r_div_a;
    assign div_b    = r_div_b;

endmodule

// File: tb/tb_prime_check.sv
// tb_prime_check
// Directed, self-checking bench for prime_check.
// It includes a small behavioural divider that can be forced into its
// error response.
// Expected values are hand-computed.
// When PRIME_CHECK_ODD_STEP_EN is defined, the expected trial counts and
// divisor sequences follow the odd-step build.
module tb_prime_check;

    localparam int WIDTH = 16;

`ifdef PRIME_CHECK_ODD_STEP_EN
    localparam int TRIALS25 = 3;
    localparam int LAST13   = 5;
`else
    localparam int TRIALS25 = 4;
    localparam int LAST13   = 4;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             go;
    logic [WIDTH-1:0] n;
    logic             ready;
    logic             is_prime;
    logic             error;
    logic [7:0]       trials;
    logic             div_go;
    logic [WIDTH-1:0] div_a;
    logic [WIDTH-1:0] div_b;
    logic             div_ready;
    logic             div_error;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] div_r;

    int checks = 0;
    int errors = 0;
    int goCount = 0;
    logic [WIDTH-1:0] divLog[$];
    logic forceErr = 1'b0;

    prime_check #(.WIDTH_LOG(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .go        (go),
        .n         (n),
        .ready     (ready),
        .is_prime  (is_prime),
        .error     (error),
        .trials    (trials),
        .div_go    (div_go),
        .div_a     (div_a),
        .div_b     (div_b),
        .div_ready (div_ready),
        .div_error (div_error),
        .div_q     (div_q),
        .div_r     (div_r)
    );

    always #5 clk = ~clk;

    // Behavioural divider.
    // It drops ready on the edge that takes div_go, stays busy for a
    // few cycles, then presents q/r (or an error when forced or when
    // dividing by zero).
    logic [WIDTH-1:0] mA, mB;
    int               mBusy;
    always @(posedge clk) begin
        if (rst) begin
            div_ready <= 1'b1;
            div_error <= 1'b0;
            div_q     <= '0;
            div_r     <= '0;
            mBusy     <= 0;
        end else if (mBusy != 0) begin
            mBusy <= mBusy - 1;
            if (mBusy == 1) begin
                div_ready <= 1'b1;
                if (forceErr || mB == 0) begin
                    div_error <= 1'b1;
                    div_q     <= '0;
                    div_r     <= '0;
                end else begin
                    div_error <= 1'b0;
                    div_q     <= mA / mB;
                    div_r     <= mA % mB;
                end
            end
        end else if (div_go && div_ready) begin
            div_ready <= 1'b0;
            div_error <= 1'b0;
            mA        <= div_a;
            mB        <= div_b;
            mBusy     <= 4;
        end
    end

    // Records every divisor the DUT requests.
    always @(posedge clk) begin
        if (div_go) begin
            divLog.push_back(div_b);
            goCount++;
        end
    end

    function automatic logic [31:0] logged(input int i);
        if (divLog.size() > i) return 32'(divLog[i]);
        return 32'hFFFF_FFFF;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Pulses go for one cycle with candidate v.
    // It returns at the negedge after the accepting edge.
    task automatic applyStimulus(input logic [WIDTH-1:0] v);
        @(negedge clk);
        go = 1'b1;
        n  = v;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic waitReady(input string tag);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (ready) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput(tag, 32'(done), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        go  = 1'b0;
        n   = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        $display("[TB] reset and idle");
        checkOutput("rst_ready", 32'(ready), 32'd1);
        checkOutput("rst_prime", 32'(is_prime), 32'd0);
        checkOutput("rst_error", 32'(error), 32'd0);
        checkOutput("rst_trials", 32'(trials), 32'd0);
        checkOutput("rst_nogo", 32'(goCount), 32'd0);

        $display("[TB] trivial candidates");
        applyStimulus(16'd0);
        checkOutput("n0_ready", 32'(ready), 32'd1);
        checkOutput("n0_prime", 32'(is_prime), 32'd0);
        applyStimulus(16'd2);
        checkOutput("n2_ready", 32'(ready), 32'd1);
        checkOutput("n2_prime", 32'(is_prime), 32'd1);
        applyStimulus(16'd1);
        checkOutput("n1_ready", 32'(ready), 32'd1);
        checkOutput("n1_prime", 32'(is_prime), 32'd0);
        applyStimulus(16'd3);
        checkOutput("n3_ready", 32'(ready), 32'd1);
        checkOutput("n3_prime", 32'(is_prime), 32'd1);
        checkOutput("n3_trials", 32'(trials), 32'd0);
        @(negedge clk);
        checkOutput("trivial_nogo", 32'(goCount), 32'd0);
        checkOutput("n3_hold", 32'(is_prime), 32'd1);

        $display("[TB] n=25");
        divLog.delete();
        applyStimulus(16'd25);
        checkOutput("n25_busy", 32'(ready), 32'd0);
        checkOutput("n25_divgo", 32'(div_go), 32'd1);
        checkOutput("n25_diva", 32'(div_a), 32'd25);
        checkOutput("n25_divb", 32'(div_b), 32'd2);
        @(negedge clk);
        checkOutput("n25_pulse1", 32'(div_go), 32'd0);
        waitReady("n25_timeout");
        checkOutput("n25_prime", 32'(is_prime), 32'd0);
        checkOutput("n25_trials", 32'(trials), 32'(TRIALS25));
        checkOutput("n25_count", 32'(divLog.size()), 32'(TRIALS25));
        checkOutput("n25_d0", logged(0), 32'd2);
        checkOutput("n25_d1", logged(1), 32'd3);
        checkOutput("n25_dlast", logged(TRIALS25 - 1), 32'd5);

        $display("[TB] n=13");
        divLog.delete();
        applyStimulus(16'd13);
        waitReady("n13_timeout");
        checkOutput("n13_prime", 32'(is_prime), 32'd1);
        checkOutput("n13_error", 32'(error), 32'd0);
        checkOutput("n13_trials", 32'(trials), 32'd3);
        checkOutput("n13_dlast", logged(2), 32'(LAST13));

        $display("[TB] divider error on n=9, then n=7");
        forceErr = 1'b1;
        applyStimulus(16'd9);
        waitReady("n9_timeout");
        forceErr = 1'b0;
        checkOutput("n9_ready", 32'(ready), 32'd1);
        checkOutput("n9_error", 32'(error), 32'd1);
        checkOutput("n9_prime", 32'(is_prime), 32'd0);
        checkOutput("n9_trials", 32'(trials), 32'd1);
        repeat (3) @(negedge clk);
        checkOutput("n9_hold", 32'(error), 32'd1);
        applyStimulus(16'd7);
        checkOutput("n7_errclr", 32'(error), 32'd0);
        waitReady("n7_timeout");
        checkOutput("n7_prime", 32'(is_prime), 32'd1);
        checkOutput("n7_error", 32'(error), 32'd0);
        checkOutput("n7_trials", 32'(trials), 32'd2);

        $display("[TB] n=8 with go and n disturbed while busy");
        divLog.delete();
        applyStimulus(16'd8);
        @(negedge clk);
        go = 1'b1;
        n  = 16'd101;
        @(negedge clk);
        go = 1'b0;
        n  = 16'd9;
        waitReady("n8_timeout");
        checkOutput("n8_prime", 32'(is_prime), 32'd0);
        checkOutput("n8_trials", 32'(trials), 32'd1);
        checkOutput("n8_diva", 32'(div_a), 32'd8);
        repeat (3) @(negedge clk);
        checkOutput("n8_hold_trials", 32'(trials), 32'd1);
        checkOutput("n8_hold_ready", 32'(ready), 32'd1);

        $display("[TB] reset mid-WAIT on n=65521");
        applyStimulus(16'd65521);
        repeat (2) @(negedge clk);
        checkOutput("n65521_busy", 32'(ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_ready", 32'(ready), 32'd1);
        checkOutput("midrst_prime", 32'(is_prime), 32'd0);
        checkOutput("midrst_error", 32'(error), 32'd0);
        checkOutput("midrst_trials", 32'(trials), 32'd0);
        checkOutput("midrst_divgo", 32'(div_go), 32'd0);
        checkOutput("midrst_diva", 32'(div_a), 32'd0);
        checkOutput("midrst_divb", 32'(div_b), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("postrst_ready", 32'(ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

endmodule
